// File: rtl/shift_if.sv
// Request/result handshake bundle for the pipelined shifter.
// The master side issues shift requests and the slave side returns results.
interface shift_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic         out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_err
  );
endinterface

// File: rtl/shift_stage.sv
// Two-stage valid/ready pipeline around the SLL/SRL/SRA shifters.
// Stage 1 registers the request, and stage 2 registers the selected result.
module shift_stage #(
  parameter int N = 32
) (
  input  logic    clk,
  input  logic    rst,
  shift_if.slave  bus
);
  localparam int SHW = $clog2(N);

  logic           vld_p1_q, vld_p1_d;
  logic [1:0]     op_p1_q, op_p1_d;
  logic [N-1:0]   a_p1_q, a_p1_d;
  logic [SHW-1:0] shamt_p1_q, shamt_p1_d;

  logic           vld_p2_q, vld_p2_d;
  logic [N-1:0]   result_p2_q, result_p2_d;
  logic           err_p2_q, err_p2_d;

  logic           s2_advance, in_ready, in_fire, out_fire, s1_move;
  logic [N:0]     shift_res;
  logic [N-SHW-1:0] unused_b_hi;

  // Bit N of the return value is the illegal-op flag.
  function automatic logic [N:0] shift_sel(input logic [1:0] op,
                                           input logic [N-1:0] a,
                                           input logic [SHW-1:0] sh);
    logic signed [N-1:0] sa;
    logic [N-1:0]        r;
    sa = a;
    r  = '0;
    case (op)
      2'b00:   r = a << sh;
      2'b01:   r = a >> sh;
      2'b10:   r = sa >>> sh;
      default: r = '0;
    endcase
    return {(op == 2'b11), r};
  endfunction

  assign unused_b_hi = bus.in_b[N-1:SHW];

  always_comb begin
    s2_advance = !vld_p2_q || bus.out_ready;
    in_ready   = !vld_p1_q || s2_advance;
    in_fire    = bus.in_valid && in_ready;
    out_fire   = vld_p2_q && bus.out_ready;
    s1_move    = vld_p1_q && s2_advance;
    shift_res  = shift_sel(op_p1_q, a_p1_q, shamt_p1_q);

    vld_p1_d   = vld_p1_q;
    op_p1_d    = op_p1_q;
    a_p1_d     = a_p1_q;
    shamt_p1_d = shamt_p1_q;
    if (in_fire) begin
      vld_p1_d   = 1'b1;
      op_p1_d    = bus.in_op;
      a_p1_d     = bus.in_a;
      shamt_p1_d = bus.in_b[SHW-1:0];
    end else if (s1_move) begin
      vld_p1_d   = 1'b0;
    end

    vld_p2_d    = vld_p2_q;
    result_p2_d = result_p2_q;
    err_p2_d    = err_p2_q;
    if (s1_move) begin
      vld_p2_d    = 1'b1;
      result_p2_d = shift_res[N-1:0];
      err_p2_d    = shift_res[N];
    end else if (out_fire) begin
      vld_p2_d    = 1'b0;
    end
  end

  // Stage 1 boundary: the request operands carry no reset.
  always_ff @(posedge clk) begin
    op_p1_q    <= op_p1_d;
    a_p1_q     <= a_p1_d;
    shamt_p1_q <= shamt_p1_d;
  end

  // Stage 2 boundary: the result is cleared on reset, so out_result reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      result_p2_q <= '0;
      err_p2_q    <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      result_p2_q <= result_p2_d;
      err_p2_q    <= err_p2_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = vld_p2_q;
  assign bus.out_result = result_p2_q;
  assign bus.out_err    = err_p2_q;
endmodule

// File: tb/tb_shift_stage.sv
// Scoreboard bench for shift_stage: accepted requests push model results,
// and output transfers are collected and compared in order.
module tb_shift_stage;
  typedef logic [32:0] ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_if #(.N(32)) bus ();
  shift_stage #(.N(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  ent_t exp_q[$];
  ent_t got_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   last_in_fire;
  bit   last_out_fire;

  function automatic ent_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sh;
    logic [31:0] r;
    sh = {27'b0, b[4:0]};
    r  = 32'h0;
    for (int i = 0; i < 32; i++) begin
      case (op)
        2'b00:   r[i] = (i >= sh) ? a[i-sh] : 1'b0;
        2'b01:   r[i] = (i + sh < 32) ? a[i+sh] : 1'b0;
        2'b10:   r[i] = (i + sh < 32) ? a[i+sh] : a[31];
        default: r[i] = 1'b0;
      endcase
    end
    return {(op == 2'b11), r};
  endfunction

  // One clock: sample handshakes well before the edge, step past the edge.
  task automatic tick();
    bit inf, outf;
    #1;
    inf  = bus.in_valid && bus.in_ready && !rst;
    outf = bus.out_valid && bus.out_ready && !rst;
    if (inf)  exp_q.push_back(model(bus.in_op, bus.in_a, bus.in_b));
    if (outf) got_q.push_back({bus.out_err, bus.out_result});
    last_in_fire  = inf;
    last_out_fire = outf;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    int guard = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (got_q.size() < exp_q.size() && guard < 300) begin
      tick();
      guard++;
    end
    ok = (got_q.size() == exp_q.size());
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_a = a; bus.in_b = b;
    do begin
      tick();
      guard++;
    end while (!last_in_fire && guard < 50);
    bus.in_valid = 1'b0;
    ok = last_in_fire;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_op     = 2'($urandom);
      bus.in_a      = $urandom;
      bus.in_b      = $urandom;
      bus.out_ready = 1'($urandom);
      @(negedge clk);
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result got %h want 0", bus.out_result); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %b want 0", bus.out_err); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    bit   ok;
    ent_t g, e;
    logic [31:0] want [4] = '{32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'h0000_0000};
    bus.out_ready = 1'b1;
    send(2'b00, 32'h0000_0001, 32'd31, ok);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early got %b want 0", bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_result !== 32'h8000_0000) begin n_fail++; $display("FAIL latency_result got %h want 80000000", bus.out_result); end
    send(2'b01, 32'h8000_0000, 32'd4, ok);
    send(2'b10, 32'h8000_0000, 32'd4, ok);
    send(2'b10, 32'h7FFF_FFFF, 32'd31, ok);
    drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL directed_drain got %0d want %0d results", got_q.size(), exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++; if (g !== {1'b0, want[i]}) begin n_fail++; $display("FAIL directed_%0d got %h want %h", i, g, {1'b0, want[i]}); end
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL directed_model_%0d got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_boundaries();
    bit   ok;
    ent_t g, e;
    logic [31:0] a0;
    ent_t want [5];
    a0 = 32'hA5C3_1E97;
    bus.out_ready = 1'b1;
    for (int op = 0; op < 3; op++) begin
      send(2'(op), a0, 32'hFFFF_FFE0, ok);
      want[op] = {1'b0, a0};
    end
    send(2'b00, 32'hFFFF_FFFF, 32'h25, ok);
    want[3] = {1'b0, 32'hFFFF_FFE0};
    send(2'b11, 32'hDEAD_BEEF, 32'h3, ok);
    want[4] = {1'b1, 32'h0};
    drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL boundary_drain got %0d want %0d results", got_q.size(), exp_q.size()); end
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++; if (g !== want[i]) begin n_fail++; $display("FAIL boundary_%0d got %h want %h", i, g, want[i]); end
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL boundary_model_%0d got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_backpressure();
    bit          ok;
    ent_t        g, e;
    logic [31:0] held;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_op = 2'(i); bus.in_a = 32'h1234_5678 + i; bus.in_b = 32'd3 + i;
      tick();
      n_cmp++; if (last_in_fire !== 1'b1) begin n_fail++; $display("FAIL bp_accept_%0d got %b want 1", i, last_in_fire); end
    end
    bus.in_op = 2'b10; bus.in_a = 32'h8765_4321; bus.in_b = 32'd7;
    held = bus.out_result;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got %b want 0", i, bus.in_ready); end
      tick();
      n_cmp++; if (bus.out_result !== held) begin n_fail++; $display("FAIL bp_stable_%0d got %h want %h", i, bus.out_result, held); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    tick();
    n_cmp++; if (last_in_fire !== 1'b1) begin n_fail++; $display("FAIL bp_third_accept got %b want 1", last_in_fire); end
    drain(ok);
    n_cmp++; if (!ok || got_q.size() != 3) begin n_fail++; $display("FAIL bp_drain got %0d want 3 results", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL bp_order got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    int   fires = 0;
    int   sent  = 0;
    int   guard = 0;
    int   errs  = 0;
    ent_t g, e;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_op = 2'($urandom_range(0, 2)); bus.in_a = $urandom; bus.in_b = $urandom;
      tick();
      if (last_in_fire) fires++;
    end
    n_cmp++; if (fires != 20) begin n_fail++; $display("FAIL throughput got %0d want 20 accepts", fires); end
    while (sent < 1000 && guard < 20000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_op     = 2'($urandom);
      bus.in_a      = $urandom;
      bus.in_b      = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_in_fire) sent++;
      guard++;
    end
    n_cmp++; if (sent != 1000) begin n_fail++; $display("FAIL stream_sent got %0d want 1000", sent); end
    drain(ok);
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stream_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== e) errs++;
      n_cmp++; if (g !== e) begin n_fail++; if (errs <= 5) $display("FAIL stream_data got %h want %h", g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_midstream();
    bit ok;
    bus.out_ready = 1'b0;
    send(2'b00, 32'h0000_00FF, 32'd4, ok);
    send(2'b01, 32'hFF00_0000, 32'd8, ok);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got %b want 1", bus.out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_clear got %b want 0", bus.out_valid); end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mid_dropped got %0d want 0 outputs", got_q.size()); end
    send(2'b10, 32'h8000_0001, 32'd1, ok);
    drain(ok);
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== {1'b0, 32'hC000_0000}) begin
      n_fail++; $display("FAIL mid_recover got %0d results first %h want 1 result %h", got_q.size(), got_q.size() ? got_q[0] : 33'h0, {1'b0, 32'hC000_0000});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_a = 32'h0; bus.in_b = 32'h0; bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got still running want finished");
    $fatal(1);
  end
endmodule
